// File: rtl/julia_iter_ctrl.sv
// julia_iter_ctrl: per-pixel Julia-set iteration sequencer.
// Hands z and c to an external calculator and waits for its result.
// It then counts iterations and stops on escape or after MAX_ITER iterations.
// The finished pixel is presented on a valid/ready output.
// Optional feature: define JL_ITER_STATS_EN to add the stat_iter_total and
// stat_pixels statistics outputs.
// JL_MUL is the fixed-point scale and normally comes from def.h.

`ifndef JL_MUL
`define JL_MUL 500
`endif

module julia_iter_ctrl #(
  parameter int unsigned        MAX_ITER   = 255,
  parameter int unsigned        ITER_W     = 8,
  parameter logic signed [31:0] ESC_THRESH = 32'(4 * `JL_MUL * `JL_MUL)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [31:0]  in_x0,
  input  logic signed [31:0]  in_y0,
  input  logic signed [31:0]  in_cr,
  input  logic signed [31:0]  in_ci,
  output logic                calc_en,
  output logic signed [31:0]  calc_x,
  output logic signed [31:0]  calc_y,
  output logic signed [31:0]  calc_cr,
  output logic signed [31:0]  calc_ci,
  input  logic                calc_done,
  input  logic signed [31:0]  calc_xn,
  input  logic signed [31:0]  calc_yn,
  input  logic signed [31:0]  calc_mag2,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ITER_W-1:0]   out_iter,
  output logic                out_escaped
`ifdef JL_ITER_STATS_EN
  ,
  output logic [31:0]         stat_iter_total,
  output logic [31:0]         stat_pixels
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_EVAL,
    S_REARM,
    S_OUT
  } state_t;

  localparam logic [ITER_W-1:0] MAX_ITER_W = ITER_W'(MAX_ITER);

  state_t               state;
  state_t               state_n;

  logic signed [31:0]   zx;
  logic signed [31:0]   zy;
  logic signed [31:0]   cr;
  logic signed [31:0]   ci;
  logic signed [31:0]   xn_q;
  logic signed [31:0]   yn_q;
  logic signed [31:0]   mag2_q;
  logic [ITER_W-1:0]    iter;
  logic [ITER_W-1:0]    iter_inc;
  logic                 escape;
  logic                 last_iter;

  // A negative mag2 means the calculator overflowed, so it also counts as an escape.
  always_comb begin
    iter_inc  = iter + ITER_W'(1);
    escape    = (mag2_q > ESC_THRESH) || mag2_q[31];
    last_iter = (iter_inc == MAX_ITER_W);
  end

  assign calc_x  = zx;
  assign calc_y  = zy;
  assign calc_cr = cr;
  assign calc_ci = ci;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  // Next-state logic. When escape and the iteration limit hit on the same
  // iteration, the escape is reported.
  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:  if (in_valid) state_n = S_ISSUE;
      S_ISSUE: if (calc_done) state_n = S_EVAL;
      S_EVAL:  state_n = (escape || last_iter) ? S_OUT : S_REARM;
      S_REARM: state_n = S_ISSUE;
      S_OUT:   if (out_ready) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Handshake and enable outputs, decoded from the current state
  always_comb begin
    in_ready  = 1'b0;
    calc_en   = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      S_IDLE:  in_ready  = 1'b1;
      S_ISSUE: calc_en   = 1'b1;
      S_OUT:   out_valid = 1'b1;
      default: ;
    endcase
  end

  // Datapath: job capture, calculator result capture, iteration bookkeeping.
  // Calculator results are captured only in ISSUE, so calc_done in any other
  // state has no effect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zx          <= '0;
      zy          <= '0;
      cr          <= '0;
      ci          <= '0;
      xn_q        <= '0;
      yn_q        <= '0;
      mag2_q      <= '0;
      iter        <= '0;
      out_iter    <= '0;
      out_escaped <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (in_valid) begin
            zx   <= in_x0;
            zy   <= in_y0;
            cr   <= in_cr;
            ci   <= in_ci;
            iter <= '0;
          end
        end
        S_ISSUE: begin
          if (calc_done) begin
            xn_q   <= calc_xn;
            yn_q   <= calc_yn;
            mag2_q <= calc_mag2;
          end
        end
        S_EVAL: begin
          iter <= iter_inc;
          if (escape || last_iter) begin
            out_iter    <= iter_inc;
            out_escaped <= escape;
          end else begin
            zx <= xn_q;
            zy <= yn_q;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef JL_ITER_STATS_EN
  // Statistics: one count per evaluated iteration and one per delivered pixel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_iter_total <= '0;
      stat_pixels     <= '0;
    end else begin
      if (state == S_EVAL)
        stat_iter_total <= stat_iter_total + 32'd1;
      if (state == S_OUT && out_ready)
        stat_pixels <= stat_pixels + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_julia_iter_ctrl.sv
// tb_julia_iter_ctrl: self-checking bench for julia_iter_ctrl.
// It contains a behavioural calculator that raises done one cycle after calc_en.
// It also holds a pixel-level reference model.

`ifndef JL_MUL
`define JL_MUL 500
`endif

module tb_julia_iter_ctrl;

  localparam int MUL      = `JL_MUL;
  localparam int MAX_ITER = 255;
  localparam int THR      = 4 * MUL * MUL;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic signed [31:0] in_x0 = '0, in_y0 = '0, in_cr = '0, in_ci = '0;
  logic               calc_en;
  logic signed [31:0] calc_x, calc_y, calc_cr, calc_ci;
  logic               calc_done;
  logic signed [31:0] calc_xn, calc_yn, calc_mag2;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic [7:0]         out_iter;
  logic               out_escaped;
`ifdef JL_ITER_STATS_EN
  logic [31:0]        stat_iter_total, stat_pixels;
`endif

  julia_iter_ctrl #(
    .MAX_ITER   (MAX_ITER),
    .ITER_W     (8),
    .ESC_THRESH (THR)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_x0       (in_x0),
    .in_y0       (in_y0),
    .in_cr       (in_cr),
    .in_ci       (in_ci),
    .calc_en     (calc_en),
    .calc_x      (calc_x),
    .calc_y      (calc_y),
    .calc_cr     (calc_cr),
    .calc_ci     (calc_ci),
    .calc_done   (calc_done),
    .calc_xn     (calc_xn),
    .calc_yn     (calc_yn),
    .calc_mag2   (calc_mag2),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_iter    (out_iter),
    .out_escaped (out_escaped)
`ifdef JL_ITER_STATS_EN
    ,
    .stat_iter_total (stat_iter_total),
    .stat_pixels     (stat_pixels)
`endif
  );

  always #5 clk = ~clk;

  // One Julia step z' = z^2 + c in fixed point; mag2 = xn^2 + yn^2 unscaled, 32-bit wrap
  function automatic void calc_step(input int x, input int y, input int cr, input int ci,
                                    output int xn, output int yn, output int mag2);
    longint lx, ly, sx, sy, m;
    lx = x;
    ly = y;
    sx = (lx * lx - ly * ly) / MUL + cr;
    sy = (2 * lx * ly) / MUL + ci;
    xn = int'(sx);
    yn = int'(sy);
    m  = longint'(xn) * longint'(xn) + longint'(yn) * longint'(yn);
    mag2 = int'(m);
  endfunction

  // Reference: iterate until escape or MAX_ITER iterations
  function automatic void ref_pixel(input int x0, input int y0, input int cr, input int ci,
                                    output int iters, output bit esc);
    int x, y, xn, yn, m;
    x = x0;
    y = y0;
    iters = MAX_ITER;
    esc = 1'b0;
    for (int n = 1; n <= MAX_ITER; n++) begin
      calc_step(x, y, cr, ci, xn, yn, m);
      if (m > THR || m < 0) begin
        iters = n;
        esc = 1'b1;
        break;
      end
      x = xn;
      y = yn;
    end
  endfunction

  // Behavioural calculator plus optional forced mag2 and spurious-done injection
  logic cdone_q = 1'b0;
  int   cxn_q = 0, cyn_q = 0, cmag_q = 0;
  bit   force_en = 1'b0;
  int   force_mag = 0;
  bit   junk_en = 1'b0;

  always @(posedge clk) begin : calc_model
    int xn, yn, m;
    if (calc_en && !cdone_q) begin
      calc_step(calc_x, calc_y, calc_cr, calc_ci, xn, yn, m);
      cdone_q <= 1'b1;
      cxn_q   <= xn;
      cyn_q   <= yn;
      cmag_q  <= force_en ? force_mag : m;
    end else begin
      cdone_q <= 1'b0;
    end
  end

  assign calc_done = cdone_q | (junk_en & ~calc_en);
  assign calc_xn   = (junk_en && !calc_en) ? 32'sd12345 : cxn_q;
  assign calc_yn   = (junk_en && !calc_en) ? 32'sd777 : cyn_q;
  assign calc_mag2 = (junk_en && !calc_en) ? -32'sd1 : cmag_q;

  // Count calc_en pulses (rising edges)
  int   pulses = 0;
  logic en_d = 1'b0;
  always @(posedge clk) begin
    en_d <= calc_en;
    if (calc_en && !en_d) pulses <= pulses + 1;
  end

  int n_pass = 0;
  int n_chk  = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // Start and end on a falling edge; runs one job through to transfer
  task automatic run_job(input string nm, input int x0, input int y0, input int cr,
                         input int ci, input int exp_iter, input bit exp_esc);
    int cyc, p0;
    cyc = 0;
    while (!in_ready && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    in_x0 = x0; in_y0 = y0; in_cr = cr; in_ci = ci;
    in_valid = 1'b1;
    p0 = pulses;
    @(negedge clk);
    in_valid = 1'b0;
    check({nm, " accept->calc_en"}, calc_en, 1);
    cyc = 0;
    while (!out_valid && cyc < 1100) begin
      @(negedge clk);
      cyc++;
    end
    check({nm, " out_valid"}, out_valid, 1);
    check({nm, " latency"}, cyc, 4 * exp_iter - 1);
    check({nm, " out_iter"}, out_iter, exp_iter);
    check({nm, " out_escaped"}, out_escaped, exp_esc);
    check({nm, " calc_en pulses"}, pulses - p0, exp_iter);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({nm, " idle after xfer"}, {out_valid, in_ready}, 2'b01);
  endtask

  typedef struct {
    string name;
    int    x0, y0, cr, ci;
    bit    fen;
    int    fmag;
    int    exp_iter;
    bit    exp_esc;
  } vec_t;

  vec_t vt[10];

  initial begin
    int cyc, n, iters, rv_out;
    bit esc, prev;
    int rx0, ry0, rcr, rci;

    vt[0] = '{"zero",       0,         0, 0,        0, 1'b0, 0,       255, 1'b0};
    vt[1] = '{"x0=3",       3 * MUL,   0, 0,        0, 1'b0, 0,       1,   1'b1};
    vt[2] = '{"x0=40000",   40000*MUL, 0, 0,        0, 1'b0, 0,       1,   1'b1};
    vt[3] = '{"mag=THR",    0,         0, 0,        0, 1'b1, THR,     255, 1'b0};
    vt[4] = '{"mag=THR+1",  0,         0, 0,        0, 1'b1, THR + 1, 1,   1'b1};
    vt[5] = '{"mag=-1",     0,         0, 0,        0, 1'b1, -1,      1,   1'b1};
    vt[6] = '{"mag=min",    0,         0, 0,        0, 1'b1, 32'h8000_0000, 1, 1'b1};
    vt[7] = '{"x0=1.2",     600,       0, 0,        0, 1'b0, 0,       2,   1'b1};
    vt[8] = '{"c=-2",       0,         0, -2 * MUL, 0, 1'b0, 0,       255, 1'b0};
    vt[9] = '{"c=2.5",      0,         0, 1250,     0, 1'b0, 0,       1,   1'b1};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst calc_en", calc_en, 0);
    check("rst out_valid", out_valid, 0);
    check("rst out_iter", out_iter, 0);
    check("rst out_escaped", out_escaped, 0);
    check("rst in_ready", in_ready, 1);
    rst_n = 1'b1;
    @(negedge clk);

`ifdef JL_ITER_STATS_EN
    run_job("stats zero", 0, 0, 0, 0, 255, 1'b0);
    run_job("stats x0=3", 3 * MUL, 0, 0, 0, 1, 1'b1);
    check("stat_iter_total", stat_iter_total, 256);
    check("stat_pixels", stat_pixels, 2);
`endif

    // Table-driven vectors
    for (int i = 0; i < 10; i++) begin
      force_en  = vt[i].fen;
      force_mag = vt[i].fmag;
      run_job(vt[i].name, vt[i].x0, vt[i].y0, vt[i].cr, vt[i].ci,
              vt[i].exp_iter, vt[i].exp_esc);
      force_en = 1'b0;
    end

    // Back-pressure: result must hold while out_ready is low; next job queued
    in_x0 = 3 * MUL; in_y0 = 0; in_cr = 0; in_ci = 0;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check("bp out_valid", out_valid, 1);
    in_x0 = 0; in_cr = 1250;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      check("bp hold valid/ready", {out_valid, in_ready}, 2'b10);
      check("bp hold iter", out_iter, 1);
      check("bp hold esc", out_escaped, 1);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp in_ready after xfer", in_ready, 1);
    check("bp out_iter held", out_iter, 1);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp next job accepted", calc_en, 1);
    cyc = 0;
    while (!out_valid && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check("bp job2 iter", out_iter, 1);
    check("bp job2 esc", out_escaped, 1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // Spurious calc_done outside ISSUE must be ignored
    junk_en = 1'b1;
    run_job("junk done", 600, 0, 0, 0, 2, 1'b1);
    junk_en = 1'b0;

    // Reset asserted in the ISSUE state of iteration 5
    in_x0 = 0; in_y0 = 0; in_cr = -2 * MUL; in_ci = 0;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    prev = 1'b0;
    cyc = 0;
    while (cyc < 100) begin
      if (calc_en && !prev) n++;
      if (n == 5) break;
      prev = calc_en;
      @(negedge clk);
      cyc++;
    end
    check("rst reached iter5 issue", n, 5);
    #2 rst_n = 1'b0;
    #1;
    check("midrst calc_en", calc_en, 0);
    check("midrst out_valid", out_valid, 0);
    check("midrst out_iter", out_iter, 0);
    check("midrst calc_cr", calc_cr, 0);
    check("midrst in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    rv_out = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (out_valid) rv_out++;
    end
    check("midrst no output", rv_out, 0);
    run_job("after rst", 3 * MUL, 0, 0, 0, 1, 1'b1);

    // Randomized jobs against the reference model
    for (int i = 0; i < 12; i++) begin
      rx0 = int'($urandom_range(4 * MUL)) - 2 * MUL;
      ry0 = int'($urandom_range(4 * MUL)) - 2 * MUL;
      rcr = int'($urandom_range(2 * MUL)) - MUL;
      rci = int'($urandom_range(2 * MUL)) - MUL;
      ref_pixel(rx0, ry0, rcr, rci, iters, esc);
      run_job("random", rx0, ry0, rcr, rci, iters, esc);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
